countdown_timer: RTL and testbench

- Hour/minute/second countdown timer: the down-counting counterpart of the free-running time-of-day counter.
- Operator loads a duration (hh:mm:ss), starts, pauses and resumes it; the block decrements once per second and flags expiry.
- Sits beside the time-of-day counter, feeding the same display path.
- Host/UI logic drives the load/start/pause strobes.

---
 rtl/countdown_timer.sv | 97 +++++++++
 tb/tb_countdown_timer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Hour/minute/second countdown timer. Loads hh:mm:ss, counts down one
// second per TICKS_PER_SEC clocks while running, pulses done on reaching zero.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [5:0]    dec_hour, dec_min, dec_sec;
  logic          load_ok, time_zero, dec_zero;

  assign load_ok   = (load_hour <= 6'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
  assign time_zero = (hour == 6'd0) && (min == 6'd0) && (sec == 6'd0);
  assign dec_zero  = (dec_hour == 6'd0) && (dec_min == 6'd0) && (dec_sec == 6'd0);

  // Borrow chain for one-second decrement; never evaluated on zero time.
  always_comb begin
    dec_hour = hour;
    dec_min  = min;
    dec_sec  = sec - 6'd1;
    if (sec == 6'd0) begin
      dec_sec = 6'd59;
      dec_min = min - 6'd1;
      if (min == 6'd0) begin
        dec_min  = 6'd59;
        dec_hour = hour - 6'd1;
      end
    end
  end

  // Control FSM, prescaler and time registers. A load strobe (accepted or
  // not) owns the cycle; a rejected load in RUN does not disturb counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      hour     <= 6'd0;
      min      <= 6'd0;
      sec      <= 6'd0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= load && (state == RUN || !load_ok);
      if (load && load_ok && state != RUN) begin
        hour    <= load_hour;
        min     <= load_min;
        sec     <= load_sec;
        presc   <= '0;
        state   <= IDLE;
        running <= 1'b0;
      end else if (!load && pause && state == RUN) begin
        state   <= PAUSED;
        running <= 1'b0;
      end else if (!load && start && (state == IDLE || state == PAUSED) && !time_zero) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (state == RUN) begin
        if (presc == TERM) begin
          presc <= '0;
          hour  <= dec_hour;
          min   <= dec_min;
          sec   <= dec_sec;
          if (dec_zero) begin
            state   <= EXPIRED;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a fast instance (TICKS_PER_SEC=4) for
// the functional sequence and a default-rate instance for mid-second reset.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, pause;
  logic [5:0] load_hour, load_min, load_sec;
  logic [5:0] hour, min, sec;
  logic       running, done, load_err;

  logic       reset2, load2, start2, pause2;
  logic [5:0] hour2, min2, sec2;
  logic       running2, done2, load_err2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(4)) u_dut (
    .clk(clk), .reset(reset), .load(load), .load_hour(load_hour),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .hour(hour), .min(min), .sec(sec), .running(running), .done(done),
    .load_err(load_err)
  );

  countdown_timer u_big (
    .clk(clk), .reset(reset2), .load(load2), .load_hour(6'd0),
    .load_min(6'd10), .load_sec(6'd0), .start(start2), .pause(pause2),
    .hour(hour2), .min(min2), .sec(sec2), .running(running2), .done(done2),
    .load_err(load_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk(tag, {14'd0, hour, min, sec}, {14'd0, 6'(h), 6'(m), 6'(s)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_hour = 6'(h); load_min = 6'(m); load_sec = 6'(s);
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; tick(1); pause = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_hour = '0; load_min = '0; load_sec = '0;
    reset2 = 1'b1; load2 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
    #22;
    // reset state
    chk_time("rst_time", 0, 0, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_load_err", load_err, 0);
    reset = 1'b0; reset2 = 1'b0;
    tick(1);

    // start with zero time is ignored
    do_start();
    chk("zero_start_running", running, 0);
    tick(5);
    chk("zero_start_done", done, 0);
    chk_time("zero_start_time", 0, 0, 0);

    // borrow chain 01:00:00
    do_load(1, 0, 0);
    chk_time("borrow_load", 1, 0, 0);
    chk("borrow_load_err", load_err, 0);
    do_start();
    chk("borrow_running", running, 1);
    tick(3);
    chk_time("borrow_3cyc", 1, 0, 0);
    tick(1);
    chk_time("borrow_4cyc", 0, 59, 59);
    chk("borrow_done4", done, 0);
    tick(4);
    chk_time("borrow_8cyc", 0, 59, 58);
    chk("borrow_done8", done, 0);

    // load during RUN rejected, countdown keeps pace
    do_load(0, 0, 2);
    chk("run_load_err", load_err, 1);
    chk_time("run_load_time", 0, 59, 58);
    tick(1);
    chk("run_load_err_clr", load_err, 0);
    tick(2);
    chk_time("run_load_dec", 0, 59, 57);
    chk("run_load_running", running, 1);
    do_pause();
    chk("pause_running", running, 0);

    // expiry from 00:00:02
    do_load(0, 0, 2);
    chk_time("exp_load", 0, 0, 2);
    do_start();
    tick(3);
    chk_time("exp_3cyc", 0, 0, 2);
    tick(1);
    chk_time("exp_4cyc", 0, 0, 1);
    chk("exp_running_mid", running, 1);
    tick(3);
    chk("exp_done_early", done, 0);
    tick(1);
    chk_time("exp_8cyc", 0, 0, 0);
    chk("exp_done", done, 1);
    chk("exp_running", running, 0);
    tick(1);
    chk("exp_done_clr", done, 0);
    do_start();
    chk("exp_start_ignored", running, 0);
    tick(4);
    chk_time("exp_hold", 0, 0, 0);
    chk("exp_no_redone", done, 0);

    // load validation
    do_load(24, 0, 0);
    chk("bad_hour_err", load_err, 1);
    chk_time("bad_hour_time", 0, 0, 0);
    tick(1);
    chk("bad_hour_err_clr", load_err, 0);
    do_load(0, 60, 0);
    chk("bad_min_err", load_err, 1);
    do_load(0, 0, 60);
    chk("bad_sec_err", load_err, 1);
    chk_time("bad_sec_time", 0, 0, 0);
    do_load(23, 59, 59);
    chk("max_load_err", load_err, 0);
    chk_time("max_load_time", 23, 59, 59);
    chk("max_load_running", running, 0);

    // pause/resume: prescaler held at 2 across the pause
    do_load(0, 0, 5);
    do_start();
    tick(2);
    do_pause();
    chk("pr_paused", running, 0);
    tick(20);
    chk_time("pr_hold", 0, 0, 5);
    do_start();
    chk("pr_resume", running, 1);
    tick(1);
    chk_time("pr_resume_1", 0, 0, 5);
    tick(1);
    chk_time("pr_resume_2", 0, 0, 4);
    pause = 1'b1; start = 1'b1;
    tick(1);
    pause = 1'b0; start = 1'b0;
    chk("ps_same_cycle", running, 0);
    tick(10);
    chk_time("ps_hold", 0, 0, 4);

    // mid-second reset on the full-rate instance
    load2 = 1'b1; tick(1); load2 = 1'b0;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(500);
    chk("big_running", running2, 1);
    chk("big_time", {hour2, min2, sec2}, {6'd0, 6'd10, 6'd0});
    #3 reset2 = 1'b1;
    #1;
    chk("big_rst_time", {hour2, min2, sec2}, 18'd0);
    chk("big_rst_running", running2, 0);
    chk("big_rst_flags", {done2, load_err2}, 2'b00);
    tick(1);
    reset2 = 1'b0;
    tick(1);
    start2 = 1'b1; tick(1); start2 = 1'b0;
    chk("big_start_ignored", running2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
